sa_ctrl: RTL and testbench

SA_CTRL -- requirements
Module: sa_ctrl

---
 rtl/sa_ctrl_if.sv | 41 ++++
 rtl/sa_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_sa_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_ctrl_if.sv
// Requester, response and serial-adder signal bundle for sa_ctrl.
// slave: the controller side; master: requesters, consumer and adder.
interface sa_ctrl_if;
    logic       req0_valid;
    logic [1:0] req0_a;
    logic [1:0] req0_b;
    logic       req0_ready;
    logic       req1_valid;
    logic [1:0] req1_a;
    logic [1:0] req1_b;
    logic       req1_ready;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_id;
    logic [2:0] resp_sum;
    logic       resp_err;
    logic       sa_en_i;
    logic       sa_ina;
    logic       sa_inb;
    logic       sa_out;
    logic       sa_en_o;
    logic       busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  resp_ready, sa_out, sa_en_o,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_sum, resp_err,
        output sa_en_i, sa_ina, sa_inb, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output resp_ready, sa_out, sa_en_o,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_sum, resp_err,
        input  sa_en_i, sa_ina, sa_inb, busy
    );
endinterface

// File: rtl/sa_ctrl.sv
// Two-requester front end for a bit-serial 2-bit adder: arbitrates,
// serialises operands LSB first, collects the MSB-first sum, responds.
module sa_ctrl #(
    parameter int TIMEOUT = 8
) (
    input  logic      clk,
    input  logic      rst,
    sa_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND0,
        S_SEND1,
        S_WAIT,
        S_RECV,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
    localparam logic [3:0] RECV_LAST = 4'd2;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       id_q, id_d;
    logic [1:0] a_q, a_d;
    logic [1:0] b_q, b_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] res_q, res_d;
    logic       en_prev_q, en_prev_d;
    logic       sa_en_i_q, sa_en_i_d;
    logic       sa_ina_q, sa_ina_d;
    logic       sa_inb_q, sa_inb_d;
    logic       resp_valid_q, resp_valid_d;
    logic       resp_id_q, resp_id_d;
    logic [2:0] resp_sum_q, resp_sum_d;
    logic       resp_err_q, resp_err_d;
    logic       busy_q, busy_d;

    logic       can_grant;
    logic       win1;
    logic       gnt0;
    logic       gnt1;
    logic       en_rise;

    // ptr_q holds the last granted requester; the other one wins a tie
    always_comb begin
        can_grant = (state_q == S_IDLE) && !resp_valid_q && !rst;
        win1      = bus.req1_valid && (!bus.req0_valid || !ptr_q);
        gnt0      = can_grant && bus.req0_valid && !win1;
        gnt1      = can_grant && win1;
        en_rise   = bus.sa_en_o && !en_prev_q;
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        en_prev_d    = bus.sa_en_o;
        sa_en_i_d    = 1'b0;
        sa_ina_d     = 1'b0;
        sa_inb_d     = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    id_d      = gnt1;
                    ptr_d     = gnt1;
                    a_d       = gnt1 ? bus.req1_a : bus.req0_a;
                    b_d       = gnt1 ? bus.req1_b : bus.req0_b;
                    sa_en_i_d = 1'b1;
                    sa_ina_d  = a_d[0];
                    sa_inb_d  = b_d[0];
                    state_d   = S_SEND0;
                end
            end
            S_SEND0: begin
                sa_en_i_d = 1'b1;
                sa_ina_d  = a_q[1];
                sa_inb_d  = b_q[1];
                state_d   = S_SEND1;
            end
            S_SEND1: begin
                // a level already high on WAIT entry must not count as a rise
                en_prev_d = 1'b1;
                cnt_d     = 4'd0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (en_rise) begin
                    cnt_d   = 4'd0;
                    state_d = S_RECV;
                end else if (cnt_q == WAIT_LAST) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_sum_d   = 3'd0;
                    resp_err_d   = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RECV: begin
                res_d = {res_q[1:0], bus.sa_out};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == RECV_LAST) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_sum_d   = res_d;
                    resp_err_d   = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= 2'd0;
            b_q          <= 2'd0;
            cnt_q        <= 4'd0;
            res_q        <= 3'd0;
            en_prev_q    <= 1'b1;
            sa_en_i_q    <= 1'b0;
            sa_ina_q     <= 1'b0;
            sa_inb_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_sum_q   <= 3'd0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            en_prev_q    <= en_prev_d;
            sa_en_i_q    <= sa_en_i_d;
            sa_ina_q     <= sa_ina_d;
            sa_inb_q     <= sa_inb_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.sa_en_i    = sa_en_i_q;
    assign bus.sa_ina     = sa_ina_q;
    assign bus.sa_inb     = sa_inb_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_sa_ctrl.sv
// Directed bench for sa_ctrl with a behavioural serial adder and a
// response scoreboard.
module tb_sa_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   no_en = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic [4:0] sb[$];

    sa_ctrl_if bus();

    sa_ctrl #(.TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // serial adder: en_o rises 3 cycles after the first en_i cycle,
    // then sum bits MSB first on the next three cycles
    logic [1:0] ma, mb;
    logic [2:0] ms;
    int         ph;
    always @(posedge clk) begin
        if (rst) begin
            ph          <= 0;
            bus.sa_en_o <= 1'b0;
            bus.sa_out  <= 1'b0;
        end else begin
            case (ph)
                0: if (bus.sa_en_i) begin
                    ma[0] <= bus.sa_ina;
                    mb[0] <= bus.sa_inb;
                    ph    <= 1;
                end
                1: begin
                    ma[1] <= bus.sa_ina;
                    mb[1] <= bus.sa_inb;
                    ph    <= 2;
                end
                2: begin
                    ms <= {1'b0, ma} + {1'b0, mb};
                    if (!no_en) bus.sa_en_o <= 1'b1;
                    ph <= 3;
                end
                3: begin bus.sa_out <= ms[2]; ph <= 4; end
                4: begin bus.sa_out <= ms[1]; ph <= 5; end
                5: begin bus.sa_out <= ms[0]; ph <= 6; end
                default: begin
                    bus.sa_en_o <= 1'b0;
                    bus.sa_out  <= 1'b0;
                    ph          <= 0;
                end
            endcase
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit id, input logic [1:0] a,
                            input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (no_en) sb.push_back({id, 3'd0, 1'b1});
        else       sb.push_back({id, s, 1'b0});
    endtask

    task automatic wait_grant(output bit id, output int hs);
        #1;
        for (int k = 0; k < 40; k++) begin
            if (bus.req0_ready || bus.req1_ready) break;
            step();
            #1;
        end
        chk("grant_seen", 8'(bus.req0_ready | bus.req1_ready), 8'd1);
        id = bus.req1_ready;
        hs = cyc;
    endtask

    task automatic req(input bit id, input logic [1:0] a,
                       input logic [1:0] b, output int hs);
        bit g;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        wait_grant(g, hs);
        chk("grant_id", 8'(g), 8'(id));
        push_exp(id, a, b);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic collect(output int seen);
        logic [4:0] e;
        for (int k = 0; k < 40; k++) begin
            if (bus.resp_valid) break;
            step();
        end
        seen = cyc;
        chk("resp_seen", 8'(bus.resp_valid), 8'd1);
        chk("sb_nonempty", 8'(sb.size() > 0), 8'd1);
        e = (sb.size() > 0) ? sb.pop_front() : 5'd0;
        chk("resp_id", 8'(bus.resp_id), 8'(e[4]));
        chk("resp_sum", 8'(bus.resp_sum), 8'(e[3:1]));
        chk("resp_err", 8'(bus.resp_err), 8'(e[0]));
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        chk("idle_busy", 8'(bus.busy), 8'd0);
        chk("idle_valid", 8'(bus.resp_valid), 8'd0);
    endtask

    initial begin
        int a_hs, seen, hs;
        bit g;
        logic [1:0] pa0 [2];
        logic [1:0] pb0 [2];
        logic [1:0] pa1 [2];
        logic [1:0] pb1 [2];
        int n0, n1;
        logic [4:0] snap;
        bit leak;

        pa0 = '{2'd1, 2'd3}; pb0 = '{2'd2, 2'd3};
        pa1 = '{2'd2, 2'd0}; pb1 = '{2'd1, 2'd3};

        bus.req0_valid = 1'b1; bus.req0_a = 2'd3; bus.req0_b = 2'd3;
        bus.req1_valid = 1'b1; bus.req1_a = 2'd3; bus.req1_b = 2'd3;
        bus.resp_ready = 1'b1;

        // reset with everything asserted
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_outs", {bus.busy, bus.resp_valid, bus.resp_id,
                bus.resp_sum, bus.sa_en_i, bus.sa_ina}, 8'd0);
            chk("rst_misc", 8'({bus.resp_err, bus.sa_inb}), 8'd0);
            chk("rst_ready", 8'({bus.req0_ready, bus.req1_ready}), 8'd0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b0;
        rst = 1'b0;
        step();

        // round robin with both requesters pending
        n0 = 0; n1 = 0;
        bus.req0_valid = 1'b1; bus.req0_a = pa0[0]; bus.req0_b = pb0[0];
        bus.req1_valid = 1'b1; bus.req1_a = pa1[0]; bus.req1_b = pb1[0];
        for (int gi = 0; gi < 4; gi++) begin
            wait_grant(g, hs);
            chk("rr_order", 8'(g), 8'(gi % 2));
            if (g) push_exp(1'b1, bus.req1_a, bus.req1_b);
            else   push_exp(1'b0, bus.req0_a, bus.req0_b);
            step();
            if (!g) begin
                n0++;
                if (n0 < 2) begin
                    bus.req0_a = pa0[n0]; bus.req0_b = pb0[n0];
                end else bus.req0_valid = 1'b0;
            end else begin
                n1++;
                if (n1 < 2) begin
                    bus.req1_a = pa1[n1]; bus.req1_b = pb1[n1];
                end else bus.req1_valid = 1'b0;
            end
            collect(seen);
        end

        // single transfer: serial bits and latency
        req(1'b0, 2'd3, 2'd2, a_hs);
        chk("send0", 8'({bus.sa_en_i, bus.sa_ina, bus.sa_inb}), 8'b110);
        step();
        chk("send1", 8'({bus.sa_en_i, bus.sa_ina, bus.sa_inb}), 8'b111);
        step();
        chk("wait_en", 8'({bus.sa_en_i, bus.sa_ina, bus.sa_inb}), 8'b000);
        collect(seen);
        chk("latency", 8'(seen - a_hs), 8'd8);

        // consumer stalls for 5 cycles
        req(1'b1, 2'd2, 2'd2, a_hs);
        for (int k = 0; k < 40; k++) begin
            if (bus.resp_valid) break;
            step();
        end
        snap = {bus.resp_id, bus.resp_sum, bus.resp_err};
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("hold_resp", 8'({bus.resp_id, bus.resp_sum, bus.resp_err}),
                8'({1'b1, 3'd4, 1'b0}));
            chk("hold_busy", 8'({bus.busy, bus.resp_valid}), 8'b11);
            chk("hold_ready", 8'({bus.req0_ready, bus.req1_ready}), 8'd0);
            step();
            #1;
        end
        chk("hold_stable", 8'({bus.resp_id, bus.resp_sum, bus.resp_err}),
            8'(snap));
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        collect(seen);

        // adder never answers
        no_en = 1'b1;
        req(1'b0, 2'd1, 2'd1, a_hs);
        collect(seen);
        chk("timeout_lat", 8'(seen - a_hs), 8'd11);
        no_en = 1'b0;
        step();

        // reset in the middle of RECV
        req(1'b0, 2'd2, 2'd3, a_hs);
        for (int k = 0; k < 20; k++) begin
            if (cyc >= a_hs + 6) break;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_front());
        chk("abort_outs", 8'({bus.busy, bus.resp_valid, bus.sa_en_i}), 8'd0);
        leak = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.resp_valid) leak = 1'b1;
        end
        chk("abort_noresp", 8'(leak), 8'd0);
        req(1'b1, 2'd1, 2'd1, a_hs);
        collect(seen);
        chk("post_abort_lat", 8'(seen - a_hs), 8'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
